// File: rtl/add_pipe_sched_pkg.sv
// Shared defaults and types for the pipelined adder scheduler.
package add_pipe_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int LAT_DEF  = 9;

    // Full adder result: carry-out in bit 8, sum in bits 7:0.
    typedef logic [8:0] res_t;

    // Requester tag width; a single requester still gets one bit.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_pipe_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past each winner.
module rr_arb
    import add_pipe_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int TW   = tag_w(NREQ_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [TW-1:0]   gnt_idx
);

    logic [TW-1:0] ptr_q, ptr_d;
    logic          found;

    // Scan from the pointer with wraparound; first requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (en) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = (int'(ptr_q) + off) % NREQ;
                if (!found && req[idx]) begin
                    found       = 1'b1;
                    gnt[idx]    = 1'b1;
                    gnt_idx     = TW'(idx);
                end
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/add_pipe_sched.sv
// Shared 8-bit adder pipeline serving NREQ requesters with round-robin issue,
// tagged responses after LAT non-held cycles, and a global hold/freeze.
module add_pipe_sched
    import add_pipe_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic              hold,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_sum,
    output logic              rsp_cout,
    output logic              busy,
    output logic [15:0]       issue_cnt
);

    localparam int TW = tag_w(NREQ);

    logic [NREQ-1:0] gnt;
    logic [TW-1:0]   gnt_idx;
    logic            accept;
    logic [7:0]      op_a, op_b;
    logic            op_cin;
    res_t            op_sum;

    // Stage 0 is loaded on the accept edge; stage LAT drives the response.
    logic [LAT:0]    vld_q, vld_d;
    logic [TW-1:0]   tag_q [LAT+1];
    logic [TW-1:0]   tag_d [LAT+1];
    res_t            res_q [LAT+1];
    res_t            res_d [LAT+1];
    logic [15:0]     cnt_q, cnt_d;

    rr_arb #(
        .NREQ (NREQ),
        .TW   (TW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (!hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // Select the winner's operands and form the 9-bit result.
    always_comb begin
        op_a   = req_a[8*int'(gnt_idx) +: 8];
        op_b   = req_b[8*int'(gnt_idx) +: 8];
        op_cin = req_cin[gnt_idx];
        op_sum = {1'b0, op_a} + {1'b0, op_b} + res_t'(op_cin);
    end

    // Shift valid/tag/result down the chain unless frozen by hold.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        res_d = res_q;
        if (!hold) begin
            vld_d    = {vld_q[LAT-1:0], accept};
            tag_d[0] = gnt_idx;
            res_d[0] = op_sum;
            for (int j = 1; j <= LAT; j++) begin
                tag_d[j] = tag_q[j-1];
                res_d[j] = res_q[j-1];
            end
        end
    end

    // Saturating acceptance counter.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Control state: valid bits and counter are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Datapath registers carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        res_q <= res_d;
    end

    // One-hot response strobe to the issuing requester, suppressed during hold.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (vld_q[LAT] && !hold && int'(tag_q[LAT]) == i) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_sum   = res_q[LAT][7:0];
    assign rsp_cout  = res_q[LAT][8];
    assign busy      = |vld_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_add_pipe_sched.sv
// Self-checking bench for add_pipe_sched with a queue-based reference model.
module tb_add_pipe_sched;
    import add_pipe_sched_pkg::*;

    localparam int N = 4;
    localparam int L = 9;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_cin, rsp_valid;
    logic [8*N-1:0] req_a, req_b;
    logic           hold, rsp_cout, busy;
    logic [7:0]     rsp_sum;
    logic [15:0]    issue_cnt;

    add_pipe_sched #(.NREQ(N), .LAT(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .hold      (hold),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Driven values, also seen by the model at each edge.
    logic           drv_rst_n;
    logic [N-1:0]   drv_valid, drv_cin;
    logic [8*N-1:0] drv_a, drv_b;
    logic           drv_hold;

    // Reference model: pending responses ordered by the non-held edge count at which they show.
    typedef struct {
        int     tag;
        int     sum;
        longint due;
    } ent_t;
    ent_t   m_q[$];
    int     m_ptr;
    int     m_cnt;
    longint m_nh;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] m_grant(input logic [N-1:0] v, input logic h, input int ptr);
        logic [N-1:0] g;
        logic         done;
        g    = '0;
        done = 1'b0;
        if (!h) begin
            for (int k = 0; k < N; k++) begin
                if (!done && v[(ptr + k) % N]) begin
                    g[(ptr + k) % N] = 1'b1;
                    done = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_ptr = 0;
        m_cnt = 0;
        m_nh  = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] g;
        int           gi;
        ent_t         e;
        if (!drv_rst_n) begin
            model_clear();
        end else if (!drv_hold) begin
            m_nh++;
            g = m_grant(drv_valid, drv_hold, m_ptr);
            if (g != '0) begin
                gi    = onehot_idx(g);
                e.tag = gi;
                e.sum = int'(drv_a[8*gi +: 8]) + int'(drv_b[8*gi +: 8]) + int'(drv_cin[gi]);
                e.due = m_nh + L;
                m_q.push_back(e);
                m_ptr = (gi + 1) % N;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        while (m_q.size() > 0 && m_q[0].due < m_nh) void'(m_q.pop_front());
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rv;
        exp_rv = '0;
        if (drv_rst_n && !drv_hold && m_q.size() > 0 && m_q[0].due == m_nh)
            exp_rv[m_q[0].tag] = 1'b1;
        check("req_ready", req_ready, m_grant(drv_valid, drv_hold, m_ptr));
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != '0) begin
            check("rsp_sum", rsp_sum, m_q[0].sum % 256);
            check("rsp_cout", rsp_cout, m_q[0].sum / 256);
        end
        check("busy", busy, (m_q.size() > 0) ? 1 : 0);
        check("issue_cnt", issue_cnt, m_cnt);
    endtask

    task automatic apply();
        rst_n     = drv_rst_n;
        req_valid = drv_valid;
        req_a     = drv_a;
        req_b     = drv_b;
        req_cin   = drv_cin;
        hold      = drv_hold;
        if (!drv_rst_n) model_clear();
        #1;
        check_outputs();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        apply();
        finish_cycle();
    endtask

    task automatic do_reset();
        drv_rst_n = 1'b0;
        drv_valid = '0;
        drv_hold  = 1'b0;
        step();
        step();
        drv_rst_n = 1'b1;
    endtask

    typedef struct {
        int         rq;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;
    vec_t vecs[6];

    int          tags[$];
    int          cyc[$];
    int          found_edge;
    int          seen;
    logic [N-1:0] exp_gnt[5];

    initial begin
        vecs[0] = '{rq: 2, a: 8'hFF, b: 8'h01, cin: 1'b1, exp_sum: 8'h01, exp_cout: 1'b1};
        vecs[1] = '{rq: 0, a: 8'h00, b: 8'h00, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b0};
        vecs[2] = '{rq: 1, a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1};
        vecs[3] = '{rq: 3, a: 8'h80, b: 8'h80, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[4] = '{rq: 0, a: 8'h12, b: 8'h34, cin: 1'b1, exp_sum: 8'h47, exp_cout: 1'b0};
        vecs[5] = '{rq: 3, a: 8'h7F, b: 8'h00, cin: 1'b1, exp_sum: 8'h80, exp_cout: 1'b0};
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;
        exp_gnt[4] = 4'b0001;

        drv_a   = '0;
        drv_b   = '0;
        drv_cin = '0;
        model_clear();
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_cnt", issue_cnt, 0);

        // Contention from reset: grants rotate 0,1,2,3,0.
        drv_valid = '1;
        for (int k = 0; k < 5; k++) begin
            drv_a = {$urandom, $urandom};
            drv_b = {$urandom, $urandom};
            drv_cin = 4'($urandom);
            apply();
            check("contend_gnt", req_ready, exp_gnt[k]);
            finish_cycle();
        end
        drv_valid = '0;
        for (int k = 0; k < 40 && tags.size() < 5; k++) begin
            apply();
            if (rsp_valid != '0) begin
                tags.push_back(onehot_idx(rsp_valid));
                cyc.push_back(k);
            end
            finish_cycle();
        end
        check("contend_rsp_count", tags.size(), 5);
        for (int k = 0; k < tags.size() && k < 5; k++) begin
            check("contend_rsp_tag", tags[k], onehot_idx(exp_gnt[k]));
            if (k > 0) check("contend_rsp_gap", cyc[k] - cyc[k-1], 1);
        end

        // Table-driven single operations.
        foreach (vecs[v]) begin
            drv_valid = '0;
            drv_valid[vecs[v].rq] = 1'b1;
            drv_a = {$urandom, $urandom};
            drv_b = {$urandom, $urandom};
            drv_cin = 4'($urandom);
            drv_a[8*vecs[v].rq +: 8] = vecs[v].a;
            drv_b[8*vecs[v].rq +: 8] = vecs[v].b;
            drv_cin[vecs[v].rq] = vecs[v].cin;
            step();
            drv_valid = '0;
            for (int k = 0; k < L; k++) step();
            check("single_rsp_valid", rsp_valid, 1 << vecs[v].rq);
            check("single_sum", rsp_sum, vecs[v].exp_sum);
            check("single_cout", rsp_cout, vecs[v].exp_cout);
            check("single_busy_high", busy, 1);
            step();
            check("single_busy_low", busy, 0);
            check("single_rsp_gone", rsp_valid, 0);
        end

        // Hold for edges 4..6 after an accept: response after 12 edges.
        drv_valid = 4'b0010;
        drv_a[15:8] = 8'h55;
        drv_b[15:8] = 8'h0A;
        drv_cin[1]  = 1'b1;
        step();
        found_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            drv_hold  = (e >= 4 && e <= 6);
            drv_valid = drv_hold ? 4'hF : 4'h0;
            apply();
            if (drv_hold) check("hold_ready_zero", req_ready, 0);
            if (drv_hold) check("hold_busy", busy, 1);
            if (found_edge < 0 && rsp_valid != '0) begin
                found_edge = e - 1;
                check("hold_rsp_tag", rsp_valid, 4'b0010);
                check("hold_rsp_sum", {rsp_cout, rsp_sum}, 9'h060);
            end
            finish_cycle();
        end
        drv_hold  = 1'b0;
        drv_valid = '0;
        check("hold_latency", found_edge, 12);

        // Reset mid-flight discards everything.
        seen = 0;
        drv_valid = '1;
        for (int k = 0; k < 5; k++) step();
        drv_valid = '0;
        for (int k = 0; k < 4; k++) step();
        do_reset();
        for (int k = 0; k < L + 5; k++) begin
            apply();
            if (rsp_valid != '0) seen++;
            finish_cycle();
        end
        check("rst_no_rsp", seen, 0);
        check("rst_cnt", issue_cnt, 0);
        check("rst_busy", busy, 0);
        drv_valid = '1;
        apply();
        check("rst_ptr_zero", req_ready, 4'b0001);
        finish_cycle();
        drv_valid = '0;

        // Randomized traffic with hold against the model.
        for (int k = 0; k < 3000; k++) begin
            drv_valid = 4'($urandom);
            drv_hold  = ($urandom_range(0, 9) == 0);
            drv_a     = {$urandom, $urandom};
            drv_b     = {$urandom, $urandom};
            drv_cin   = 4'($urandom);
            step();
        end
        drv_valid = '0;
        drv_hold  = 1'b0;
        for (int k = 0; k < L + 3; k++) step();
        check("drain_busy", busy, 0);

        // Saturation: 65537 acceptances with random operands.
        do_reset();
        drv_valid = '1;
        for (int k = 0; k < 65537; k++) begin
            drv_a   = {$urandom, $urandom};
            drv_b   = {$urandom, $urandom};
            drv_cin = 4'($urandom);
            step();
        end
        check("sat_cnt", issue_cnt, 16'hFFFF);
        for (int k = 0; k < 3; k++) step();
        check("sat_cnt_stays", issue_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
